// File: rtl/accel_spi_pkg.sv
// accel_spi_pkg: command/address constants and FSM encoding shared by the accelerometer SPI model.
package accel_spi_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ = 8'h0B;
  localparam logic [7:0] ADDR_DEVID = 8'h00;
  localparam logic [7:0] ADDR_AXIS8_BASE = 8'h08;
  localparam logic [7:0] ADDR_AXIS16_BASE = 8'h0E;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_RD,
    ST_ADDR_WR,
    ST_DATA_RD,
    ST_DATA_WR,
    ST_IGNORE
  } state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchroniser plus registered rise/fall detector for an asynchronous pin.
module spi_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] s_q;
  logic rise_q, fall_q;
  // The chain keeps tracking the pin during reset so release never fakes an edge.
  always_ff @(posedge clk) begin
    s_q <= {s_q[1:0], d_i};
    rise_q <= resetn && s_q[1] && !s_q[2];
    fall_q <= resetn && !s_q[1] && s_q[2];
  end
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/spi_accel_slave_model.sv
// spi_accel_slave_model: oversampled SPI-slave accelerometer emulator with register map and burst access.
module spi_accel_slave_model
  import accel_spi_pkg::*;
#(
  parameter int N_AXES = 3,
  parameter int AXIS_W = 12,
  parameter int ADDR_W = 6,
  parameter logic [7:0] DEVID = 8'hAD,
  parameter logic [ADDR_W-1:0] WR_BASE = 6'h1F
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     cs_n,
  input  logic                     sclk,
  input  logic                     mosi,
  output logic                     miso,
  input  logic [N_AXES*AXIS_W-1:0] sample,
  input  logic                     sample_valid,
  output logic                     busy,
  output logic                     cmd_err,
  output logic [7:0]               txn_count
);
  localparam int NRW = 2**ADDR_W - int'(WR_BASE);
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] rx_q, rx_d, tx_q, tx_d;
  logic [7:0] txn_q, txn_d, rd_byte, rx_byte;
  logic [ADDR_W-1:0] addr_q, addr_d, rd_addr;
  logic miso_q, miso_d, err_q, err_d, cmd_ok_q, cmd_ok_d, load_q, load_d, we;
  logic [1:0] mosi_q;
  logic cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic [AXIS_W-1:0] axis_q [N_AXES];
  logic [N_AXES*AXIS_W-1:0] pend_q, ld_sample;
  logic pend_v_q;
  logic [7:0] rw_q [NRW];
  logic [15:0] sx;
  spi_sync_edge u_cs (.clk(clk), .resetn(resetn), .d_i(cs_n), .rise_o(cs_rise), .fall_o(cs_fall));
  spi_sync_edge u_sclk (.clk(clk), .resetn(resetn), .d_i(sclk), .rise_o(sclk_rise), .fall_o(sclk_fall));
  assign busy = state_q != ST_IDLE;
  assign miso = miso_q;
  assign cmd_err = err_q;
  assign txn_count = txn_q;
  assign ld_sample = sample_valid ? sample : pend_q;
  // First fall after the address byte reads addr itself; later reloads read the next address.
  always_comb begin
    rd_addr = load_q ? addr_q : addr_q + 1'b1;
    rd_byte = 8'h00;
    sx = '0;
    if (8'(rd_addr) == ADDR_DEVID) rd_byte = DEVID;
    for (int i = 0; i < N_AXES; i++) begin
      sx = 16'(signed'(axis_q[i]));
      if (8'(rd_addr) == ADDR_AXIS8_BASE + 8'(i)) rd_byte = axis_q[i][AXIS_W-1 -: 8];
      if (8'(rd_addr) == ADDR_AXIS16_BASE + 8'(2*i)) rd_byte = axis_q[i][7:0];
      if (8'(rd_addr) == ADDR_AXIS16_BASE + 8'(2*i+1)) rd_byte = sx[15:8];
    end
    if (rd_addr >= WR_BASE) rd_byte = rw_q[rd_addr - WR_BASE];
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rx_d = rx_q;
    tx_d = tx_q;
    addr_d = addr_q;
    miso_d = miso_q;
    err_d = 1'b0;
    txn_d = txn_q;
    cmd_ok_d = cmd_ok_q;
    load_d = load_q;
    we = 1'b0;
    rx_byte = {rx_q, mosi_q[1]};
    if (cs_rise && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      miso_d = 1'b0;
      txn_d = txn_q + 8'(cmd_ok_q);
      cmd_ok_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_d = cs_fall ? ST_CMD : ST_IDLE;
      cnt_d = '0;
    end else if (sclk_rise && state_q != ST_DATA_RD && state_q != ST_IGNORE) begin
      rx_d = rx_byte[6:0];
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == 3'd7) begin
        if (state_q == ST_CMD) begin
          cmd_ok_d = 1'b1;
          err_d = rx_byte != CMD_READ && rx_byte != CMD_WRITE;
          state_d = rx_byte == CMD_READ ? ST_ADDR_RD : rx_byte == CMD_WRITE ? ST_ADDR_WR : ST_IGNORE;
        end else if (state_q == ST_DATA_WR) begin
          we = addr_q >= WR_BASE;
          addr_d = addr_q + 1'b1;
        end else begin
          addr_d = rx_byte[ADDR_W-1:0];
          load_d = 1'b1;
          state_d = state_q == ST_ADDR_RD ? ST_DATA_RD : ST_DATA_WR;
        end
      end
    end else if (sclk_fall && state_q == ST_DATA_RD) begin
      cnt_d = cnt_q + 1'b1;
      tx_d = {tx_q[5:0], 1'b0};
      miso_d = tx_q[6];
      if (load_q || cnt_q == 3'd7) begin
        cnt_d = '0;
        tx_d = rd_byte[6:0];
        miso_d = rd_byte[7];
        load_d = 1'b0;
        addr_d = rd_addr;
      end
    end
  end
  always_ff @(posedge clk) begin
    mosi_q <= {mosi_q[0], mosi};
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      addr_q <= '0;
      miso_q <= 1'b0;
      err_q <= 1'b0;
      txn_q <= '0;
      cmd_ok_q <= 1'b0;
      load_q <= 1'b0;
      pend_q <= '0;
      pend_v_q <= 1'b0;
      for (int i = 0; i < N_AXES; i++) axis_q[i] <= '0;
      for (int i = 0; i < NRW; i++) rw_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      addr_q <= addr_d;
      miso_q <= miso_d;
      err_q <= err_d;
      txn_q <= txn_d;
      cmd_ok_q <= cmd_ok_d;
      load_q <= load_d;
      if (we) rw_q[addr_q - WR_BASE] <= rx_byte;
      // Axis registers only move while idle; strobes during a transaction wait in pend_q.
      if (sample_valid && busy) begin
        pend_q <= sample;
        pend_v_q <= 1'b1;
      end else if (!busy && (sample_valid || pend_v_q)) begin
        pend_v_q <= 1'b0;
        for (int i = 0; i < N_AXES; i++) axis_q[i] <= ld_sample[i*AXIS_W +: AXIS_W];
      end
    end
  end
endmodule

// File: tb/tb_spi_accel_slave_model.sv
// tb_spi_accel_slave_model: SPI master driver with a register-map reference model and a miso byte scoreboard.
module tb_spi_accel_slave_model;
  localparam int NA = 3;
  localparam int AW = 12;
  localparam int SW = NA * AW;
  localparam int HALF = 5;
  localparam logic [7:0] DEV = 8'hAD;
  logic clk = 1'b0;
  logic resetn, cs_n, sclk, mosi, miso, sample_valid, busy, cmd_err;
  logic [SW-1:0] sample;
  logic [7:0] txn_count;
  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int bad_m = 0;
  int txn_m = 0;
  logic [7:0] rw_m [64];
  logic [AW-1:0] ax_m [NA];
  logic [7:0] exp_q[$], got_q[$], tb_bytes[$];
  spi_accel_slave_model #(.N_AXES(NA), .AXIS_W(AW), .ADDR_W(6), .DEVID(DEV), .WR_BASE(6'h1F)) dut (
    .clk(clk), .resetn(resetn), .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso),
    .sample(sample), .sample_valid(sample_valid), .busy(busy), .cmd_err(cmd_err), .txn_count(txn_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (cmd_err) err_cnt++;
  function automatic logic [7:0] mread(input int a);
    int sv;
    if (a == 0) return DEV;
    if (a >= 'h1F) return rw_m[a];
    for (int i = 0; i < NA; i++) begin
      sv = int'(ax_m[i]);
      if (sv >= (1 << (AW - 1))) sv -= (1 << AW);
      if (a == 8 + i) return 8'((int'(ax_m[i]) >> (AW - 8)) & 255);
      if (a == 14 + 2 * i) return 8'(sv & 255);
      if (a == 15 + 2 * i) return 8'((sv >>> 8) & 255);
    end
    return 8'h00;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    txn_m = 0;
    for (int i = 0; i < 64; i++) rw_m[i] = 8'h00;
    for (int i = 0; i < NA; i++) ax_m[i] = '0;
  endtask
  task automatic spi_txn(input int rec_from, input int stop_bits, input bit rst_mid, input bit mid, input logic [SW-1:0] mv);
    int total, i, k;
    logic [7:0] r;
    total = (stop_bits >= 0) ? stop_bits : 8 * tb_bytes.size();
    r = '0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int n = 0; n < total; n++) begin
      i = n / 8;
      k = 7 - n % 8;
      mosi = tb_bytes[i][k];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      r[k] = miso;
      if (mid && i == rec_from && k == 4) begin
        @(negedge clk);
        sample = mv;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (HALF - 2) @(negedge clk);
      end else repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      if (k == 0 && i >= rec_from) got_q.push_back(r);
    end
    repeat (HALF) @(negedge clk);
    if (rst_mid) begin
      chk("miso_first_data_bit", miso, 1);
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_mid_miso", miso, 0);
      chk("rst_mid_busy", busy, 0);
    end
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic rd(input logic [7:0] a, input int n, input bit mid, input logic [SW-1:0] mv);
    tb_bytes = {8'h0B, a};
    for (int j = 0; j < n; j++) begin
      tb_bytes.push_back(8'($urandom));
      exp_q.push_back(mread((int'(a) + j) % 64));
    end
    spi_txn(2, -1, 1'b0, mid, mv);
    if (mid) for (int i = 0; i < NA; i++) ax_m[i] = mv[i*AW +: AW];
    txn_m++;
    chk("rd_txn_count", txn_count, 32'(txn_m & 255));
  endtask
  task automatic wr(input logic [7:0] a, input int n, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] d [3];
    int ad;
    d[0] = d0;
    d[1] = d1;
    d[2] = d2;
    tb_bytes = {8'h0A, a};
    for (int j = 0; j < n; j++) begin
      tb_bytes.push_back(d[j]);
      ad = (int'(a) + j) % 64;
      if (ad >= 'h1F) rw_m[ad] = d[j];
    end
    spi_txn(99, -1, 1'b0, 1'b0, '0);
    txn_m++;
    chk("wr_txn_count", txn_count, 32'(txn_m & 255));
  endtask
  task automatic bad(input logic [7:0] c);
    int e0;
    e0 = err_cnt;
    tb_bytes = {c, 8'($urandom), 8'($urandom)};
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    spi_txn(1, -1, 1'b0, 1'b0, '0);
    bad_m++;
    txn_m++;
    chk("cmd_err_pulse", err_cnt - e0, 1);
    chk("bad_txn_count", txn_count, 32'(txn_m & 255));
  endtask
  task automatic load(input logic [SW-1:0] v);
    @(negedge clk);
    sample = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    for (int i = 0; i < NA; i++) ax_m[i] = v[i*AW +: AW];
    repeat (2) @(negedge clk);
  endtask
  initial begin : monitor
    logic [7:0] g, e;
    forever begin
      @(negedge clk);
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL miso_byte got=%02h expected=none", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            failures++;
            $display("FAIL miso_byte got=%02h expected=%02h", g, e);
          end
        end
      end
    end
  end
  initial begin : watchdog
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog cycles=80000 expected=finish");
    $fatal(1, "timeout");
  end
  initial begin : stim
    logic [7:0] c;
    int kind;
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    resetn = 1'b0;
    sample = '0;
    sample_valid = 1'b0;
    model_reset();
    repeat (6) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_busy", busy, 0);
    chk("rst_txn_count", txn_count, 0);
    chk("rst_cmd_err", cmd_err, 0);
    rd(8'h00, 1, 1'b0, '0);
    load({12'h3A7, 12'h0C4, 12'hF85});
    rd(8'h0E, 2, 1'b0, '0);
    rd(8'h08, 3, 1'b0, '0);
    wr(8'h3F, 2, 8'h5A, 8'hC3, 8'h00);
    rd(8'h3F, 2, 1'b0, '0);
    bad(8'h55);
    rd(8'h0E, 2, 1'b1, {12'h123, 12'h456, 12'h7E9});
    rd(8'h0E, 6, 1'b0, '0);
    chk("idle_busy", busy, 0);
    tb_bytes = {8'h0B};
    spi_txn(99, 5, 1'b0, 1'b0, '0);
    chk("abort_busy", busy, 0);
    chk("abort_txn_count", txn_count, 32'(txn_m & 255));
    tb_bytes = {8'h0B, 8'h00, 8'h00};
    spi_txn(99, 16, 1'b1, 1'b0, '0);
    model_reset();
    chk("rst_mid_txn_count", txn_count, 0);
    rd(8'h00, 1, 1'b0, '0);
    rd(8'h0E, 2, 1'b0, '0);
    for (int t = 0; t < 28; t++) begin
      kind = int'($urandom_range(0, 4));
      if (kind == 0) wr($urandom_range(0, 1) != 0 ? 8'($urandom_range(31, 63)) : 8'($urandom),
                       int'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 8'($urandom));
      else if (kind == 1) rd(8'($urandom), int'($urandom_range(1, 4)), 1'b0, '0);
      else if (kind == 2) rd(8'($urandom_range(8, 21)), int'($urandom_range(1, 3)), 1'b1, SW'({$urandom, $urandom}));
      else if (kind == 3) load(SW'({$urandom, $urandom}));
      else begin
        c = 8'($urandom);
        while (c == 8'h0A || c == 8'h0B) c = 8'($urandom);
        bad(c);
      end
    end
    repeat (10) @(negedge clk);
    chk("cmd_err_total", err_cnt, bad_m);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
